// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one synchronous RAM (1-cycle read latency) between a 6502-style CPU
//   and a DMA requester. The CPU normally wins. A DMA that keeps losing is
//   promoted to priority for a bounded burst, and then the bus goes back to
//   the CPU. Read data is returned to whichever master issued the read, using
//   a tagged one-cycle valid pulse.
//
// Ports
//   clk, reset                   clock; asynchronous active-low reset
//   cpu_req/rw/addr/wdata        CPU request (rw: 1 = read, 0 = write)
//   cpu_rdy                      CPU access accepted this cycle (combinational)
//   cpu_rdata/cpu_rvalid         CPU read return (data passthrough, registered valid)
//   dma_req/rw/addr/wdata        DMA request
//   dma_gnt                      DMA access accepted this cycle (combinational)
//   dma_rdata/dma_rvalid         DMA read return
//   mem_addr/wdata/we, mem_rdata memory pins
module mem_bus_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int DMA_WAIT_MAX  = 8,
    parameter int DMA_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_rdy,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_rw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W  = $clog2(DMA_WAIT_MAX + 1);
    localparam int BURST_W = $clog2(DMA_BURST_MAX + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(DMA_WAIT_MAX - 1);
    localparam logic [WAIT_W-1:0]  WAIT_SAT   = WAIT_W'(DMA_WAIT_MAX);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(DMA_BURST_MAX);

    typedef enum logic { CPU_PRI = 1'b0, DMA_PRI = 1'b1 } pri_e;
    typedef enum logic [1:0] { TAG_NONE = 2'd0, TAG_CPU = 2'd1, TAG_DMA = 2'd2 } tag_e;

    pri_e               state_q,     state_d;
    logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    tag_e               rd_tag_q,    rd_tag_d;

    logic               cpu_win, dma_win, dma_lose;
    logic [BURST_W-1:0] burst_inc;

    // Grant decision. Holding reset low forces both grants to zero, so the
    // memory sees no write while the block is in reset.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (reset) begin
            if (state_q == CPU_PRI) begin
                cpu_win = cpu_req;
                dma_win = dma_req & ~cpu_req;
            end else begin
                dma_win = dma_req;
                cpu_win = cpu_req & ~dma_req;
            end
        end
    end

    assign cpu_rdy  = cpu_win;
    assign dma_gnt  = dma_win;
    assign dma_lose = dma_req & ~dma_win;

    // Memory mux. When nothing is granted, the CPU side is parked on the pins.
    always_comb begin
        if (dma_win) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = ~dma_rw;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_win & ~cpu_rw;
        end
    end

    // Read data is a plain passthrough. The tag decides who sees the valid.
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign cpu_rvalid = (rd_tag_q == TAG_CPU);
    assign dma_rvalid = (rd_tag_q == TAG_DMA);

    assign burst_inc = burst_cnt_q + 1'b1;

    // Next-state logic for the priority FSM, the fairness counters and the
    // read tag.
    // NOTE: combinational next-state logic uses blocking (=) assignments, so
    // later lines can override the defaults set at the top of the block.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        burst_cnt_d = burst_cnt_q;
        rd_tag_d    = TAG_NONE;

        if (dma_lose) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? WAIT_SAT : wait_cnt_q + 1'b1;
        end

        if (state_q == CPU_PRI) begin
            // This loss completes DMA_WAIT_MAX consecutive losses, so the DMA
            // gets priority from the next cycle.
            if (dma_lose && (wait_cnt_q == WAIT_LAST)) begin
                state_d    = DMA_PRI;
                wait_cnt_d = '0;
            end
        end else begin
            if (!dma_req) begin
                state_d     = CPU_PRI;
                burst_cnt_d = '0;
            end else if (dma_win) begin
                if (burst_inc == BURST_LAST) begin
                    state_d     = CPU_PRI;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_inc;
                end
            end
        end

        if (cpu_win && cpu_rw) begin
            rd_tag_d = TAG_CPU;
        end else if (dma_win && dma_rw) begin
            rd_tag_d = TAG_DMA;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) assignments, so every
    // register samples its pre-edge next-state value at the same time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CPU_PRI;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            rd_tag_q    <= TAG_NONE;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rd_tag_q    <= rd_tag_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. A synchronous RAM model drives
//   mem_rdata. A reference model tracks the arbitration mode, consecutive
//   losses, burst length, a shadow memory and a queue of outstanding reads.
//   A compare process checks every DUT output against that model on each
//   falling edge. The directed sequences also check hand-computed literal
//   values.
module tb_mem_bus_arbiter;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 8;
    localparam int DMA_WAIT_MAX  = 8;
    localparam int DMA_BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_rw, cpu_rdy, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dma_req, dma_rw, dma_gnt, dma_rvalid;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we;

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .DMA_WAIT_MAX(DMA_WAIT_MAX), .DMA_BURST_MAX(DMA_BURST_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with a 1-cycle read latency.
    logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct { bit is_dma; logic [DATA_W-1:0] data; } rd_t;
    rd_t pend[$];
    bit  m_dma_pri = 1'b0;
    int  m_losses  = 0;
    int  m_burst   = 0;

    always @(negedge clk) begin
        bit                e_cg, e_dg, e_we, e_rc, e_rd, nxt_pri;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata, e_data;
        rd_t               p;
        if (chk_en) begin
            if (!reset) begin
                e_cg = 1'b0; e_dg = 1'b0;
            end else if (!m_dma_pri) begin
                e_cg = cpu_req; e_dg = dma_req && !cpu_req;
            end else begin
                e_dg = dma_req; e_cg = cpu_req && !dma_req;
            end
            e_addr  = e_dg ? dma_addr  : cpu_addr;
            e_wdata = e_dg ? dma_wdata : cpu_wdata;
            e_we    = e_dg ? !dma_rw   : (e_cg && !cpu_rw);

            e_rc = 1'b0; e_rd = 1'b0; e_data = '0;
            if (reset && pend.size() > 0) begin
                p = pend.pop_front();
                e_rc = !p.is_dma; e_rd = p.is_dma; e_data = p.data;
            end

            check("m_cpu_rdy",    cpu_rdy,    e_cg);
            check("m_dma_gnt",    dma_gnt,    e_dg);
            check("m_mem_addr",   mem_addr,   e_addr);
            check("m_mem_wdata",  mem_wdata,  e_wdata);
            check("m_mem_we",     mem_we,     e_we);
            check("m_cpu_rvalid", cpu_rvalid, e_rc);
            check("m_dma_rvalid", dma_rvalid, e_rd);
            if (e_rc) check("m_cpu_rdata", cpu_rdata, e_data);
            if (e_rd) check("m_dma_rdata", dma_rdata, e_data);

            if (!reset) begin
                m_dma_pri = 1'b0; m_losses = 0; m_burst = 0;
                pend.delete();
            end else begin
                if (e_cg &&  cpu_rw) pend.push_back('{1'b0, shadow[cpu_addr]});
                if (e_dg &&  dma_rw) pend.push_back('{1'b1, shadow[dma_addr]});
                if (e_cg && !cpu_rw) shadow[cpu_addr] = cpu_wdata;
                if (e_dg && !dma_rw) shadow[dma_addr] = dma_wdata;

                nxt_pri = m_dma_pri;
                if (dma_req && !e_dg) m_losses++;
                else                  m_losses = 0;
                if (!m_dma_pri) begin
                    if (m_losses == DMA_WAIT_MAX) begin
                        nxt_pri = 1'b1; m_losses = 0;
                    end
                end else if (!dma_req) begin
                    nxt_pri = 1'b0; m_burst = 0;
                end else begin
                    m_burst++;
                    if (m_burst == DMA_BURST_MAX) begin
                        nxt_pri = 1'b0; m_burst = 0;
                    end
                end
                m_dma_pri = nxt_pri;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_cpu(input logic req, input logic rw, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        cpu_req = req; cpu_rw = rw; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic rw, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        dma_req = req; dma_rw = rw; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        reset = 1'b1;
        set_cpu(1'b1, 1'b1, 16'h0010, 8'h00);
        set_dma(1'b1, 1'b0, 16'h0020, 8'h11);
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]    = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        ram[16'h0010]    = 8'hA5;
        shadow[16'h0010] = 8'hA5;
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;

        // Reset: requests are pending but nothing may be granted or written.
        tick();
        check("rst_cpu_rdy",    cpu_rdy,    1'b0);
        check("rst_dma_gnt",    dma_gnt,    1'b0);
        check("rst_mem_we",     mem_we,     1'b0);
        check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check("rst_dma_rvalid", dma_rvalid, 1'b0);
        nxt();
        reset = 1'b1;
        set_cpu(1'b0, 1'b1, '0, '0);
        set_dma(1'b0, 1'b1, '0, '0);
        tick();

        // 1: CPU-only read.
        nxt(); set_cpu(1'b1, 1'b1, 16'h0010, 8'h00); tick();
        check("t1_cpu_rdy",  cpu_rdy,  1'b1);
        check("t1_mem_we",   mem_we,   1'b0);
        check("t1_mem_addr", mem_addr, 16'h0010);
        nxt(); set_cpu(1'b0, 1'b1, '0, '0); tick();
        check("t1_cpu_rvalid", cpu_rvalid, 1'b1);
        check("t1_cpu_rdata",  cpu_rdata,  8'hA5);
        check("t1_dma_rvalid", dma_rvalid, 1'b0);

        // 2: DMA-only write, then a read-back.
        nxt(); set_dma(1'b1, 1'b0, 16'h0200, 8'h3C); tick();
        check("t2_dma_gnt",   dma_gnt,   1'b1);
        check("t2_mem_we",    mem_we,    1'b1);
        check("t2_mem_addr",  mem_addr,  16'h0200);
        check("t2_mem_wdata", mem_wdata, 8'h3C);
        nxt(); set_dma(1'b1, 1'b1, 16'h0200, 8'h00); tick();
        check("t2_rd_gnt", dma_gnt, 1'b1);
        nxt(); set_dma(1'b0, 1'b1, '0, '0); tick();
        check("t2_dma_rvalid", dma_rvalid, 1'b1);
        check("t2_dma_rdata",  dma_rdata,  8'h3C);
        check("t2_cpu_rvalid", cpu_rvalid, 1'b0);

        // 3: both masters request continuously -> 8 CPU grants : 4 DMA grants.
        nxt();
        set_cpu(1'b1, 1'b1, 16'h0040, '0);
        set_dma(1'b1, 1'b1, 16'h0500, '0);
        for (int i = 0; i < 24; i++) begin
            tick();
            check("t3_cpu_rdy", cpu_rdy, (i % 12) < 8);
            check("t3_dma_gnt", dma_gnt, (i % 12) >= 8);
            nxt();
        end

        // 4: DMA drops its request after 2 priority grants.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_cpu_rdy", cpu_rdy, i < 8);
            check("t4_dma_gnt", dma_gnt, i >= 8);
            nxt();
        end
        set_dma(1'b0, 1'b1, 16'h0500, '0); tick();
        check("t4_drop_cpu_rdy", cpu_rdy, 1'b1);
        check("t4_drop_dma_gnt", dma_gnt, 1'b0);
        nxt(); set_dma(1'b1, 1'b1, 16'h0500, '0); tick();
        check("t4_cpu_pri_rdy", cpu_rdy, 1'b1);
        check("t4_cpu_pri_gnt", dma_gnt, 1'b0);
        nxt(); set_cpu(1'b0, 1'b1, '0, '0); set_dma(1'b0, 1'b1, '0, '0); tick();

        // 5: alternating CPU and DMA reads return in order.
        nxt(); set_cpu(1'b1, 1'b1, 16'h0100, '0); tick();
        check("t5_cpu_rdy", cpu_rdy, 1'b1);
        nxt(); set_cpu(1'b0, 1'b1, '0, '0); set_dma(1'b1, 1'b1, 16'h0301, '0); tick();
        check("t5_cpu_rv0", cpu_rvalid, 1'b1);
        check("t5_cpu_rd0", cpu_rdata,  8'h5A);
        check("t5_dma_rv0", dma_rvalid, 1'b0);
        nxt(); set_dma(1'b0, 1'b1, '0, '0); set_cpu(1'b1, 1'b1, 16'h0102, '0); tick();
        check("t5_dma_rv1", dma_rvalid, 1'b1);
        check("t5_dma_rd1", dma_rdata,  8'h5B);
        check("t5_cpu_rv1", cpu_rvalid, 1'b0);
        nxt(); set_cpu(1'b0, 1'b1, '0, '0); set_dma(1'b1, 1'b1, 16'h0303, '0); tick();
        check("t5_cpu_rv2", cpu_rvalid, 1'b1);
        check("t5_cpu_rd2", cpu_rdata,  8'h58);
        nxt(); set_dma(1'b0, 1'b1, '0, '0); tick();
        check("t5_dma_rv3", dma_rvalid, 1'b1);
        check("t5_dma_rd3", dma_rdata,  8'h59);

        // 6a: reset pulse while a CPU read is outstanding.
        nxt(); set_cpu(1'b1, 1'b1, 16'h0010, '0); tick();
        check("t6_cpu_rdy", cpu_rdy, 1'b1);
        nxt(); reset = 1'b0; tick();
        check("t6_rst_cpu_rdy", cpu_rdy,    1'b0);
        check("t6_rst_rvalid",  cpu_rvalid, 1'b0);
        check("t6_rst_we",      mem_we,     1'b0);
        nxt(); reset = 1'b1; set_cpu(1'b0, 1'b1, '0, '0); tick();
        check("t6_no_cpu_rvalid", cpu_rvalid, 1'b0);
        check("t6_no_dma_rvalid", dma_rvalid, 1'b0);

        // 6b: reset pulse while in DMA priority with a DMA read outstanding.
        nxt();
        set_cpu(1'b1, 1'b1, 16'h0040, '0);
        set_dma(1'b1, 1'b1, 16'h0301, '0);
        for (int i = 0; i < 8; i++) begin
            tick();
            nxt();
        end
        tick();
        check("t6_dma_pri_gnt", dma_gnt, 1'b1);
        nxt(); reset = 1'b0; tick();
        check("t6b_rst_cpu_rdy", cpu_rdy,    1'b0);
        check("t6b_rst_dma_gnt", dma_gnt,    1'b0);
        check("t6b_rst_rvalid",  dma_rvalid, 1'b0);
        nxt(); reset = 1'b1; tick();
        check("t6b_cpu_wins",     cpu_rdy,    1'b1);
        check("t6b_dma_loses",    dma_gnt,    1'b0);
        check("t6b_no_dma_rvalid", dma_rvalid, 1'b0);

        nxt(); set_cpu(1'b0, 1'b1, '0, '0); set_dma(1'b0, 1'b1, '0, '0);
        repeat (3) begin
            tick();
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
